// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, and redirect/stall handling.
// Define IF_BRANCH_PREDICT_EN to predict backward conditional branches as taken.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        imem_wr,
  input  logic        id_ready,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_pred_taken
);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // The PC is kept as a word index so fetch addresses stay word aligned by construction.
  logic [29:0] r_pc_word;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic        r_id_pred_taken;

  logic        w_advance;
  logic [31:0] w_pc;
  logic [29:0] w_seq_word;
  logic [29:0] w_next_word;
  logic        w_pred_taken;
  logic        w_unused;

  assign w_pc       = {r_pc_word, 2'b00};
  assign w_advance  = ~r_id_valid | id_ready;
  assign w_seq_word = r_pc_word + 30'd1;

`ifdef IF_BRANCH_PREDICT_EN
  logic [31:0] w_imm_b;
  logic [31:0] w_target;
  logic        w_is_bwd_branch;

  assign w_imm_b = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                    imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign w_target        = w_pc + w_imm_b;
  assign w_is_bwd_branch = (imem_rdata[6:0] == OPC_BRANCH) && imem_rdata[31];
  assign w_pred_taken    = w_is_bwd_branch;
  assign w_next_word     = w_is_bwd_branch ? w_target[31:2] : w_seq_word;
  assign w_unused        = ^{ex_target[1:0], w_target[1:0]};
`else
  assign w_pred_taken = 1'b0;
  assign w_next_word  = w_seq_word;
  assign w_unused     = ^{ex_target[1:0], OPC_BRANCH};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc_word       <= RESET_PC[31:2];
      r_id_valid      <= 1'b0;
      r_id_instr      <= NOP_INSTR;
      r_id_pc         <= 32'h0;
      r_id_pred_taken <= 1'b0;
    end else if (ex_redirect) begin
      // Redirect wins even over a stall; the held word is squashed, id_pc is left as is.
      r_pc_word       <= ex_target[31:2];
      r_id_valid      <= 1'b0;
      r_id_instr      <= NOP_INSTR;
      r_id_pred_taken <= 1'b0;
    end else if (w_advance) begin
      r_pc_word       <= w_next_word;
      r_id_valid      <= 1'b1;
      r_id_instr      <= imem_rdata;
      r_id_pc         <= w_pc;
      r_id_pred_taken <= w_pred_taken;
    end
  end

  assign imem_addr     = w_pc;
  assign imem_wr       = 1'b0;
  assign id_valid      = r_id_valid;
  assign id_instr      = r_id_instr;
  assign id_pc         = r_id_pc;
  assign id_pred_taken = r_id_pred_taken;

endmodule
